// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO sequencing controller: operation selects,
// FSM states, the kind of operation in flight, and default sizing.
package muldiv_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_RUN    = 2'b10,
    ST_COMMIT = 2'b11
  } state_t;

  typedef enum logic {
    KIND_MULT = 1'b0,
    KIND_DIV  = 1'b1
  } kind_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the requester/datapath side and the muldiv controller.
//
// Request handshake: an operation transfers on a rising clock edge where
// op_valid=1 and op_ready=1. op_ready depends on controller state only, never
// on op_valid. While op_ready=0 the requester keeps op_valid, op_sel, op_a
// and op_b stable; the controller ignores them until it is idle again.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
) ();

  // requester side
  logic             op_valid;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             stall;
  logic             done;
  logic             div0;
  logic             timeout_err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // datapath unit side
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic             mult_busy;
  logic             div_busy;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // controller state for observation
  muldiv_pkg::state_t dbg_state;

  modport slave (
    input  op_valid, op_sel, op_a, op_b,
    input  mult_busy, div_busy, mult_hi, mult_lo, div_hi, div_lo,
    output op_ready, stall, done, div0, timeout_err, hi, lo,
    output mult_start, div_start, unit_a, unit_b, dbg_state
  );

  modport master (
    output op_valid, op_sel, op_a, op_b,
    output mult_busy, div_busy, mult_hi, mult_lo, div_hi, div_lo,
    input  op_ready, stall, done, div0, timeout_err, hi, lo,
    input  mult_start, div_start, unit_a, unit_b, dbg_state
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// RUN-phase cycle counter. Cleared on entry to RUN, counts each enabled
// cycle, and flags the enabled cycle that brings the count to TIMEOUT.
module muldiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Terminal count: this enabled cycle is the TIMEOUT-th one since clear.
  assign o_tc = i_en && (r_cnt == CW'(TIMEOUT - 1));

  // Count enabled cycles; saturate at the terminal value.
  always_ff @(posedge clock) begin
    if (!reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller between the CPU control unit and the multi-cycle
// mult/div units: launches one operation at a time, waits on the selected
// unit's busy, commits into HI/LO, and guards against a hung unit.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  muldiv_ctrl_if.slave  bus
);

  state_t           r_state;
  kind_t            r_kind;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_unit_a;
  logic [WIDTH-1:0] r_unit_b;
  logic             r_mult_start;
  logic             r_div_start;
  logic             r_done;
  logic             r_div0;
  logic             r_timeout_err;

  logic             w_busy;
  logic [WIDTH-1:0] w_unit_hi;
  logic [WIDTH-1:0] w_unit_lo;
  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_wd_tc;

  // Only the unit that was launched is observed; the other may be stale.
  assign w_busy    = (r_kind == KIND_DIV) ? bus.div_busy : bus.mult_busy;
  assign w_unit_hi = (r_kind == KIND_DIV) ? bus.div_hi   : bus.mult_hi;
  assign w_unit_lo = (r_kind == KIND_DIV) ? bus.div_lo   : bus.mult_lo;

  assign w_wd_clr = (r_state == ST_LAUNCH);
  assign w_wd_en  = (r_state == ST_RUN);

  muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_wd_clr),
    .i_en    (w_wd_en),
    .o_tc    (w_wd_tc)
  );

  // Main sequencer: state, HI/LO, operand latches and all pulse outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_kind        <= KIND_MULT;
      r_hi          <= '0;
      r_lo          <= '0;
      r_unit_a      <= '0;
      r_unit_b      <= '0;
      r_mult_start  <= 1'b0;
      r_div_start   <= 1'b0;
      r_done        <= 1'b0;
      r_div0        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mult_start  <= 1'b0;
      r_div_start   <= 1'b0;
      r_done        <= 1'b0;
      r_div0        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (op_sel_t'(bus.op_sel))
              OP_MTHI: r_hi <= bus.op_a;
              OP_MTLO: r_lo <= bus.op_a;
              OP_MULT: begin
                r_unit_a     <= bus.op_a;
                r_unit_b     <= bus.op_b;
                r_kind       <= KIND_MULT;
                r_mult_start <= 1'b1;
                r_state      <= ST_LAUNCH;
              end
              OP_DIV: begin
                if (bus.op_b == '0) begin
                  // Divide by zero never reaches the unit; HI/LO keep their values.
                  r_div0 <= 1'b1;
                end else begin
                  r_unit_a    <= bus.op_a;
                  r_unit_b    <= bus.op_b;
                  r_kind      <= KIND_DIV;
                  r_div_start <= 1'b1;
                  r_state     <= ST_LAUNCH;
                end
              end
              default: ;
            endcase
          end
        end
        // Start pulse is high during this cycle; busy is not yet meaningful.
        ST_LAUNCH: r_state <= ST_RUN;
        ST_RUN: begin
          if (!w_busy) begin
            r_done  <= 1'b1;
            r_state <= ST_COMMIT;
          end else if (w_wd_tc) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          r_hi    <= w_unit_hi;
          r_lo    <= w_unit_lo;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready    = (r_state == ST_IDLE);
  assign bus.stall       = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.div0        = r_div0;
  assign bus.timeout_err = r_timeout_err;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.mult_start  = r_mult_start;
  assign bus.div_start   = r_div_start;
  assign bus.unit_a      = r_unit_a;
  assign bus.unit_b      = r_unit_b;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural mult/div units with programmable
// latency, a vector table for the main operations, and hand-written
// sequences for back-to-back moves, the watchdog and mid-run reset.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int TO = 40;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  logic clock;
  logic reset_n;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  int mult_lat = 0;
  int div_lat  = 0;
  int mult_rem = 0;
  int div_rem  = 0;
  logic [63:0]        m_prod;
  logic signed [W-1:0] d_q;
  logic signed [W-1:0] d_r;

  vec_t vecs[10];

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached: got hang want finish");
    $fatal(1);
  end

  // Behavioural units: sample start at the falling edge, stay busy for
  // the programmed number of cycles, results stable from start onwards.
  always @(negedge clock) begin
    if (!reset_n) begin
      bus.mult_busy = 1'b0;
      bus.div_busy  = 1'b0;
      bus.mult_hi   = '0;
      bus.mult_lo   = '0;
      bus.div_hi    = '0;
      bus.div_lo    = '0;
    end else begin
      if (bus.mult_start) begin
        m_prod = {{32{bus.unit_a[W-1]}}, bus.unit_a} * {{32{bus.unit_b[W-1]}}, bus.unit_b};
        bus.mult_hi   = m_prod[63:32];
        bus.mult_lo   = m_prod[31:0];
        bus.mult_busy = (mult_lat > 0);
        mult_rem      = mult_lat;
      end else if (bus.mult_busy) begin
        if (mult_rem <= 1) bus.mult_busy = 1'b0;
        mult_rem = mult_rem - 1;
      end
      if (bus.div_start) begin
        if (bus.unit_b != '0) begin
          d_q = $signed(bus.unit_a) / $signed(bus.unit_b);
          d_r = $signed(bus.unit_a) % $signed(bus.unit_b);
        end
        bus.div_hi   = d_r;
        bus.div_lo   = d_q;
        bus.div_busy = (div_lat > 0);
        div_rem      = div_lat;
      end else if (bus.div_busy) begin
        if (div_rem <= 1) bus.div_busy = 1'b0;
        div_rem = div_rem - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request (called right after a falling edge), follow it to
  // completion and check pulses, latency and the resulting HI/LO.
  task automatic run_op(input string name, input logic [1:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    int n_exp;
    bit seen;
    int st_m, st_d, stall_lo, to_cnt;
    logic [2*W-1:0] exp_v;
    mult_lat     = lat;
    div_lat      = lat;
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clock);
    bus.op_valid = 1'b0;
    if (sel == OP_MTHI || sel == OP_MTLO || (sel == OP_DIV && b == '0)) begin
      check({name, " ready"}, bus.op_ready, 1);
      check({name, " stall"}, bus.stall, 0);
      check({name, " div0"}, bus.div0, (sel == OP_DIV) ? 1 : 0);
      check({name, " no_start"}, {bus.mult_start, bus.div_start}, 0);
      check({name, " hi"}, bus.hi, ehi);
      check({name, " lo"}, bus.lo, elo);
      @(negedge clock);
      check({name, " div0_end"}, bus.div0, 0);
    end else begin
      exp_q.push_back({ehi, elo});
      n = 1;
      check({name, " start_sel"}, {bus.mult_start, bus.div_start},
            (sel == OP_MULT) ? 2'b10 : 2'b01);
      seen = 0; st_m = 0; st_d = 0; stall_lo = 0; to_cnt = 0;
      while (!seen && n < 200) begin
        if (bus.mult_start) st_m++;
        if (bus.div_start) st_d++;
        if (!bus.stall) stall_lo++;
        if (bus.timeout_err) to_cnt++;
        if (bus.done) seen = 1;
        else begin
          @(negedge clock);
          n++;
        end
      end
      n_exp = ((lat < 1) ? 1 : lat) + 2;
      check({name, " done_seen"}, seen, 1);
      check({name, " latency"}, n, n_exp);
      check({name, " mult_starts"}, st_m, (sel == OP_MULT) ? 1 : 0);
      check({name, " div_starts"}, st_d, (sel == OP_DIV) ? 1 : 0);
      check({name, " stall_gaps"}, stall_lo, 0);
      check({name, " timeouts"}, to_cnt, 0);
      @(negedge clock);
      check({name, " done_pulse"}, bus.done, 0);
      check({name, " ready_after"}, bus.op_ready, 1);
      exp_v = exp_q.pop_front();
      check({name, " hi"}, bus.hi, exp_v[2*W-1:W]);
      check({name, " lo"}, bus.lo, exp_v[W-1:0]);
    end
  endtask

  initial begin
    int n;
    int cnt_done, cnt_to;
    bit seen;

    vecs[0] = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{OP_DIV,  32'd100,        32'd7,         32, 32'd2,         32'd14};
    vecs[2] = '{OP_MTHI, 32'h11,         32'd0,         0,  32'h11,        32'd14};
    vecs[3] = '{OP_MTLO, 32'h22,         32'd0,         0,  32'h11,        32'h22};
    vecs[4] = '{OP_DIV,  32'd5,          32'd0,         0,  32'h11,        32'h22};
    vecs[5] = '{OP_MULT, 32'h0001_0000,  32'h0001_0000, 5,  32'd1,         32'd0};
    vecs[6] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,         3,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7] = '{OP_MULT, 32'd3,          32'd5,         0,  32'd0,         32'd15};
    vecs[8] = '{OP_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 40, 32'd0,         32'd1};
    vecs[9] = '{OP_DIV,  32'hFFFF_FFF0,  32'hFFFF_FFFD, 39, 32'hFFFF_FFFF, 32'd5};

    reset_n      = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_sel   = 2'b00;
    bus.op_a     = '0;
    bus.op_b     = '0;
    repeat (3) @(negedge clock);

    // reset state
    check("rst hi", bus.hi, 0);
    check("rst lo", bus.lo, 0);
    check("rst unit_a", bus.unit_a, 0);
    check("rst unit_b", bus.unit_b, 0);
    check("rst ready", bus.op_ready, 1);
    check("rst stall", bus.stall, 0);
    check("rst pulses", {bus.mult_start, bus.div_start, bus.done, bus.div0, bus.timeout_err}, 0);
    check("rst state", bus.dbg_state, ST_IDLE);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].ehi, vecs[i].elo);
    end

    // Back-to-back MTHI then MTLO: each lands on its own edge, never stalls.
    bus.op_valid = 1'b1;
    bus.op_sel   = OP_MTHI;
    bus.op_a     = 32'hDEAD_BEEF;
    @(negedge clock);
    check("mthi hi", bus.hi, 32'hDEAD_BEEF);
    check("mthi lo_kept", bus.lo, 32'd5);
    check("mthi stall", bus.stall, 0);
    bus.op_sel = OP_MTLO;
    bus.op_a   = 32'h0BAD_F00D;
    @(negedge clock);
    bus.op_valid = 1'b0;
    check("mtlo lo", bus.lo, 32'h0BAD_F00D);
    check("mtlo hi_kept", bus.hi, 32'hDEAD_BEEF);
    check("mtlo stall", bus.stall, 0);

    // Hung multiplier: watchdog fires on the 40th busy RUN cycle.
    mult_lat     = 1000;
    bus.op_valid = 1'b1;
    bus.op_sel   = OP_MULT;
    bus.op_a     = 32'd2;
    bus.op_b     = 32'd3;
    @(negedge clock);
    bus.op_valid = 1'b0;
    n = 1; seen = 0; cnt_done = 0;
    while (!seen && n < 200) begin
      if (bus.done) cnt_done++;
      if (bus.timeout_err) seen = 1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    check("wd seen", seen, 1);
    check("wd latency", n, TO + 2);
    check("wd no_done", cnt_done, 0);
    check("wd ready", bus.op_ready, 1);
    check("wd state", bus.dbg_state, ST_IDLE);
    check("wd hi", bus.hi, 32'hDEAD_BEEF);
    check("wd lo", bus.lo, 32'h0BAD_F00D);
    @(negedge clock);
    check("wd pulse", bus.timeout_err, 0);
    run_op("div_after_wd", OP_DIV, 32'd9, 32'd2, 32, 32'd1, 32'd4);

    // Reset in the middle of RUN abandons the operation.
    bus.op_valid = 1'b1;
    bus.op_sel   = OP_MULT;
    bus.op_a     = 32'd11;
    bus.op_b     = 32'd13;
    mult_lat     = 32;
    @(negedge clock);
    bus.op_valid = 1'b0;
    repeat (10) @(negedge clock);
    check("mid state_run", bus.dbg_state, ST_RUN);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid state", bus.dbg_state, ST_IDLE);
    check("mid hi", bus.hi, 0);
    check("mid lo", bus.lo, 0);
    check("mid ready", bus.op_ready, 1);
    check("mid done", bus.done, 0);
    reset_n = 1'b1;
    cnt_done = 0; cnt_to = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clock);
      if (bus.done) cnt_done++;
      if (bus.timeout_err) cnt_to++;
    end
    check("mid no_done", cnt_done, 0);
    check("mid no_timeout", cnt_to, 0);
    run_op("mult_after_rst", OP_MULT, 32'd3, 32'd5, 32, 32'd0, 32'd15);

    check("queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
